// File: rtl/data_structs_pkg.sv
// Shared ray data types: signed 24-bit components grouped into point/vec3/ray.
// Words are ordered orig.x, orig.y, orig.z, dir.x, dir.y, dir.z (MSB first in ray).
package data_structs;

  localparam int unsigned COMP_W    = 24;
  localparam int unsigned RAY_WORDS = 6;

  typedef logic signed [COMP_W-1:0] comp_t;

  typedef struct packed {
    comp_t x;
    comp_t y;
    comp_t z;
  } point;

  typedef struct packed {
    comp_t x;
    comp_t y;
    comp_t z;
  } vec3;

  typedef struct packed {
    point orig;
    vec3  dir;
  } ray;

  // Returns r with the component at word position idx replaced by w.
  function automatic ray ray_set_word(ray r, logic [2:0] idx, comp_t w);
    ray o;
    o = r;
    case (idx)
      3'd0:    o.orig.x = w;
      3'd1:    o.orig.y = w;
      3'd2:    o.orig.z = w;
      3'd3:    o.dir.x  = w;
      3'd4:    o.dir.y  = w;
      3'd5:    o.dir.z  = w;
      default: o = r;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ray_deserializer.sv
// Assembles six 24-bit words into a ray behind a one-entry output register.
// Define RAY_DESER_FRAME_CHECK_EN to enable s_last framing checks and the drop counter.
module ray_deserializer
  import data_structs::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [COMP_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output ray                       m_ray,
  output logic                     frame_err,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam logic [2:0] LastIdx = 3'(RAY_WORDS - 1);

  logic [2:0] idx;
  ray         asm;
  logic       asm_full;
  logic       accept;
  logic       xfer;
  logic       at_last;
  logic       done;
  logic       bad;

  // A full buffer can still accept when it drains into the output register this edge.
  assign s_ready = !asm_full || !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign xfer    = asm_full && (!m_valid || m_ready);
  assign at_last = (idx == LastIdx);

`ifdef RAY_DESER_FRAME_CHECK_EN
  assign done = accept && s_last && at_last;
  assign bad  = accept && (s_last != at_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      frame_err <= bad;
      if (bad && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = s_last;
  assign done        = accept && at_last;
  assign bad         = 1'b0;
  assign frame_err   = 1'b0;
  assign drop_cnt    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      asm      <= '0;
      asm_full <= 1'b0;
      m_valid  <= 1'b0;
      m_ray    <= '0;
    end else begin
      if (accept) begin
        asm <= ray_set_word(asm, idx, s_data);
        idx <= (done || bad) ? 3'd0 : idx + 3'd1;
      end
      if (done) begin
        asm_full <= 1'b1;
      end else if (xfer) begin
        asm_full <= 1'b0;
      end
      if (xfer) begin
        m_ray   <= asm;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ray_deserializer.md
RAY_DESERIALIZER -- requirements
Module: ray_deserializer

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the dropped-frame counter.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: s_valid  input  1  word stream valid.
REQ-005 SHALL have port: s_ready  output  1  word accepted when s_valid && s_ready.
REQ-006 SHALL have port: s_data  input  24  one signed 24-bit ray component.
REQ-007 SHALL have port: s_last  input  1  marks the final (sixth) word of a ray frame.
REQ-008 SHALL have port: m_valid  output  1  assembled ray valid.
REQ-009 SHALL have port: m_ready  input  1  downstream accepts ray when m_valid && m_ready.
REQ-010 SHALL have port: m_ray  output  144  assembled ray (package ray struct).
REQ-011 SHALL have port: frame_err  output  1  one-cycle pulse per dropped frame.
REQ-012 SHALL have port: drop_cnt  output  CNT_W  count of dropped frames.

Function
REQ-013 SHALL assemble rays from six accepted words in order orig.x, orig.y, orig.z, dir.x, dir.y, dir.z, tracked by word index idx 0..5.
REQ-014 SHALL hold an assembly buffer (asm, asm_full flag) separate from the output register (m_ray, m_valid).
REQ-015 SHALL set asm_full at the edge accepting word idx 5 with s_last=1 and reset idx to 0.
REQ-016 SHALL move asm to m_ray, set m_valid, and clear asm_full at any edge where asm_full && (!m_valid || m_ready).
REQ-017 SHALL drive s_ready = !asm_full || !m_valid || m_ready (combinational), giving one word per cycle sustained with m_ready held high.
REQ-018 SHALL, on a same-edge transfer plus new word accept, send the old asm contents to m_ray while the new word writes asm field 0.
REQ-019 SHALL clear m_valid on an m_ready handshake when no transfer occurs on that edge.
REQ-020 SHALL keep m_ray and m_valid stable while m_valid && !m_ready.
REQ-021 SHALL have latency: last word accepted at edge E -> m_valid high after edge E+1 if the output register is free.
REQ-022 SHALL treat a framing error as s_last=1 at idx<5, or s_last=0 at idx 5; on it, discard the partial frame, set idx to 0, pulse frame_err for one cycle, and increment drop_cnt.
REQ-023 SHALL saturate drop_cnt at 2^CNT_W-1.
REQ-024 SHALL NOT let words arriving with s_valid=0 affect state; idx SHALL change only on accept.

Reset
REQ-025 SHALL, on rst high, asynchronously clear idx, asm, asm_full, m_valid, m_ray, frame_err, and drop_cnt to 0.
REQ-026 SHALL drop a partial frame in progress on reset without a frame_err pulse or count.
REQ-027 SHALL hold s_ready high while out of reset with state empty.

Configuration
REQ-028 SHALL, with RAY_DESER_FRAME_CHECK_EN defined, implement REQ-022/023.
REQ-029 SHALL, without RAY_DESER_FRAME_CHECK_EN, ignore s_last (idx alone frames rays, wrapping 5->0), tie frame_err to 0, and tie drop_cnt to 0.

Structure
REQ-030 SHALL use ray, point, and vec3 from the shared data_structs package; RAY_WORDS (6) SHALL be added there as a constant.
REQ-031 SHALL be a single module with no sub-module.

Verification
REQ-032 SHALL test back-to-back frames: two frames with m_ready=1 and words 1..6, 7..12 -> rays {1,2,3,4,5,6} and {7,..,12}, s_ready never low, m_valid after edge E+1.
REQ-033 SHALL test backpressure: m_ready=0 and three frames sent -> third frame's word 0 stalls (s_ready=0), first ray held stable; m_ready=1 -> all three delivered in order.
REQ-034 SHALL test early last: s_last on word 3 -> frame_err pulses once, drop_cnt=1, next clean frame is delivered intact.
REQ-035 SHALL test missing last: six words with s_last=0 -> frame dropped, drop_cnt increments.
REQ-036 SHALL test saturation: CNT_W=2 with 5 bad frames -> drop_cnt=3.
REQ-037 SHALL test reset mid-frame: rst after 3 words, then a full frame -> correct ray, frame_err never pulses.
